// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: write-pointer input, memory read port,
// Gray read pointer back to the write domain, and the output word handshake.
//
// Handshake: dout is offered while dout_valid=1 and is taken on a rising rclk
// edge where dout_valid=1 and dout_ready=1; while dout_ready=0 the offered word
// and the read pointers stay put. dout_ready may be driven regardless of
// dout_valid, and dout_valid never depends combinationally on dout_ready.
interface fifo_rd_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic [ADDRSIZE:0]   wptr;
  logic [DATASIZE-1:0] rdata;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  logic [ADDRSIZE:0]   rcount;
  logic                state_dbg;

  // Controller side.
  modport master (
    input  wptr, rdata, dout_ready,
    output raddr, rptr, rempty, dout, dout_valid, rcount, state_dbg
  );

  // Memory / write domain / consumer side.
  modport slave (
    output wptr, rdata, dout_ready,
    input  raddr, rptr, rempty, dout, dout_valid, rcount, state_dbg
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of an asynchronous FIFO: synchronizes the Gray write
// pointer, keeps the binary/Gray read pointer, produces a registered empty flag
// and a one-word output register that streams one word per cycle.
module fifo_rd_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic           rclk,
  input  logic           rrst,
  fifo_rd_ctrl_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t              state;
  logic [ADDRSIZE:0]   rq1_wptr;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE:0]   rbin;
  logic [ADDRSIZE:0]   rbin_next;
  logic [ADDRSIZE:0]   rgray_next;
  logic [ADDRSIZE:0]   rptr_q;
  logic [ADDRSIZE:0]   wbin_sync;
  logic                rempty_q;
  logic                dout_valid_q;
  logic [DATASIZE-1:0] dout_q;
  logic                pop;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Two-flop synchronizer; only rq2_wptr is used by any logic below.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rq1_wptr <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1_wptr <= bus.wptr;
      rq2_wptr <= rq1_wptr;
    end
  end

  // A word leaves memory when one is available and the output register is
  // either empty or being emptied by the consumer this cycle.
  assign pop        = !rempty_q && (!dout_valid_q || bus.dout_ready);
  assign rbin_next  = rbin + {{ADDRSIZE{1'b0}}, pop};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);

  // Read pointer and empty flag; empty looks ahead at rbin_next so the final
  // pop raises rempty in the same cycle and no pop can follow it.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin     <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbin_next;
      rptr_q   <= rgray_next;
      rempty_q <= (rgray_next == rq2_wptr);
    end
  end

  // Output stage FSM: IDLE holds nothing, VALID offers dout to the consumer.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state        <= IDLE;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state        <= VALID;
            dout_valid_q <= 1'b1;
            dout_q       <= bus.rdata;
          end
        end
        VALID: begin
          if (pop) begin
            dout_q <= bus.rdata;
          end else if (bus.dout_ready) begin
            state        <= IDLE;
            dout_valid_q <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          dout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy as seen through the synchronized write pointer; a difference
  // of DEPTH (MSBs differ, low bits equal) is the legal full case.
  assign wbin_sync = gray2bin(rq2_wptr);

  assign bus.raddr      = rbin[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rempty     = rempty_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.rcount     = wbin_sync - rbin;
  assign bus.state_dbg  = (state == VALID);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a word-count model of the read side checked every
// cycle, an expected-word queue for the output handshake, and directed tests
// with literal expectations.
module tb_fifo_rd_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic rclk = 1'b0;
  logic rrst = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();
  fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk(rclk),
    .rrst(rrst),
    .bus (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] word_log [64];
  logic [DW-1:0] exp_q [$];
  assign bus.rdata = mem[bus.raddr];

  int tests = 0;
  int fails = 0;
  bit run_chk = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int first_acc = 0;
  int last_acc = 0;
  bit seen_wrap = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  // ---------------- behavioural model (word counts) ----------------
  int w_total = 0;   // words written by the bench
  int w_d1;          // w_total seen at the last edge
  int w_seen;        // w_total seen two edges ago: what the reader knows
  int r_total;       // words popped from memory
  logic m_empty, m_valid;
  logic [DW-1:0] m_dout;
  wire m_pop = !m_empty && (!m_valid || bus.dout_ready);

  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      w_d1 <= 0; w_seen <= 0; r_total <= 0;
      m_empty <= 1'b1; m_valid <= 1'b0; m_dout <= '0;
    end else begin
      if (m_pop) begin
        m_dout  <= word_log[r_total];
        r_total <= r_total + 1;
        m_valid <= 1'b1;
      end else if (bus.dout_ready) begin
        m_valid <= 1'b0;
      end
      m_empty <= ((r_total + (m_pop ? 1 : 0)) == w_seen);
      w_seen  <= w_d1;
      w_d1    <= w_total;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge rclk) begin
    if (run_chk) begin
      check("valid",  bus.dout_valid, m_valid);
      check("state",  bus.state_dbg, m_valid);
      check("rempty", bus.rempty, m_empty);
      check("raddr",  bus.raddr, r_total % DEPTH);
      check("rptr",   bus.rptr, gray(r_total));
      check("rcount", bus.rcount, (w_seen - r_total) & 31);
      if (m_valid) check("dout", bus.dout, m_dout);
      if (bus.raddr == 0 && bus.rptr == 5'b11000) seen_wrap = 1;
    end
  end

  // Scoreboard: each accepted word must be the next one written.
  always @(posedge rclk) begin
    cyc++;
    if (!rrst && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_extra: got %0h expected no word", bus.dout);
      end else begin
        check("sb_word", bus.dout, exp_q.pop_front());
      end
      acc_cnt++;
      if (acc_cnt == 1) first_acc = cyc;
      last_acc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [DW-1:0] d);
    word_log[w_total] = d;
    mem[w_total % DEPTH] = d;
    exp_q.push_back(d);
    w_total++;
    bus.wptr = gray(w_total);
  endtask

  task automatic do_reset;
    @(negedge rclk);
    rrst = 1'b1;
    bus.dout_ready = 1'b0;
    w_total = 0;
    bus.wptr = '0;
    exp_q.delete();
    @(negedge rclk);
    rrst = 1'b0;
    acc_cnt = 0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.dout_valid) && n < 200) begin
      @(negedge rclk);
      n++;
    end
    check(name, n < 200, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus.wptr = '0;
    bus.dout_ready = 1'b0;
    #1 rrst = 1'b1;
    #1;
    check("rst_rempty", bus.rempty, 1);
    check("rst_valid",  bus.dout_valid, 0);
    check("rst_rptr",   bus.rptr, 0);
    check("rst_rcount", bus.rcount, 0);
    run_chk = 1;

    // Single word through an idle output stage.
    do_reset;
    bus.dout_ready = 1'b1;
    push(8'hA5);
    repeat (3) @(negedge rclk);
    check("sw_rempty_e3", bus.rempty, 0);
    @(negedge rclk);
    check("sw_dout_e4",   bus.dout, 8'hA5);
    check("sw_valid_e4",  bus.dout_valid, 1);
    check("sw_raddr_e4",  bus.raddr, 1);
    check("sw_rptr_e4",   bus.rptr, 5'b00001);
    check("sw_rempty_e4", bus.rempty, 1);
    @(negedge rclk);
    check("sw_valid_e5",  bus.dout_valid, 0);

    // Backpressure holds the first word.
    do_reset;
    push(8'h11);
    @(negedge rclk); push(8'h22);
    @(negedge rclk); push(8'h33);
    repeat (8) @(negedge rclk);
    check("bp_dout",   bus.dout, 8'h11);
    check("bp_raddr",  bus.raddr, 1);
    check("bp_rcount", bus.rcount, 2);
    repeat (4) @(negedge rclk);
    check("bp_hold",   bus.dout, 8'h11);
    bus.dout_ready = 1'b1;
    @(negedge rclk);
    check("bp_w2", bus.dout, 8'h22);
    @(negedge rclk);
    check("bp_w3", bus.dout, 8'h33);
    @(negedge rclk);
    check("bp_done", bus.dout_valid, 0);

    // Streaming 16 words, one per cycle.
    do_reset;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge rclk);
      push(8'(i));
    end
    wait_drain("stream_drain");
    check("stream_count", acc_cnt, 16);
    check("stream_span",  last_acc - first_acc, 15);

    // Wrap of the 5-bit pointer.
    do_reset;
    bus.dout_ready = 1'b1;
    seen_wrap = 0;
    for (int i = 0; i < 20; i++) begin
      int n;
      n = 0;
      @(negedge rclk);
      while (w_total - r_total >= DEPTH && n < 100) begin
        @(negedge rclk);
        n++;
      end
      push(8'(8'h40 + i));
    end
    wait_drain("wrap_drain");
    check("wrap_seen",  seen_wrap, 1);
    check("wrap_count", acc_cnt, 20);
    check("wrap_raddr", bus.raddr, 4);
    check("wrap_rptr",  bus.rptr, 5'b11110);

    // Full: 16 words appear at once.
    do_reset;
    for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
    @(negedge rclk);
    @(negedge rclk);
    check("full_rcount_e2",  bus.rcount, 16);
    check("full_model_cnt",  w_seen - r_total, 16);
    check("full_rempty_e2",  bus.rempty, 1);
    @(negedge rclk);
    check("full_rempty_e3",  bus.rempty, 0);
    check("full_model_emp",  m_empty, 0);
    check("full_rcount_e3",  bus.rcount, 16);
    check("full_raddr_e3",   bus.raddr, 0);
    @(negedge rclk);
    check("full_dout",       bus.dout, 8'hC0);
    check("full_model_dout", m_dout, 8'hC0);
    check("full_rcount_e4",  bus.rcount, 15);
    bus.dout_ready = 1'b1;
    wait_drain("full_drain");
    check("full_count", acc_cnt, 16);

    // Asynchronous reset mid-transfer with rbin=7.
    do_reset;
    for (int i = 0; i < 8; i++) push(8'(8'h70 + i));
    repeat (6) @(negedge rclk);
    bus.dout_ready = 1'b1;
    repeat (6) @(negedge rclk);
    bus.dout_ready = 1'b0;
    check("ar_pre_raddr", bus.raddr, 7);
    check("ar_pre_valid", bus.dout_valid, 1);
    #2;
    rrst = 1'b1;
    w_total = 0;
    bus.wptr = '0;
    exp_q.delete();
    #1;
    check("ar_valid",  bus.dout_valid, 0);
    check("ar_rempty", bus.rempty, 1);
    check("ar_rptr",   bus.rptr, 5'b00000);
    check("ar_rcount", bus.rcount, 0);
    check("ar_dout",   bus.dout, 0);
    @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);
    check("ar_resume_raddr", bus.raddr, 0);

    repeat (2) @(negedge rclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DATASIZE, 8, memory data word width.
REQ-002 Parameter ADDRSIZE, 4, memory address bits; DEPTH = 2^ADDRSIZE.
REQ-003 rclk  input  1  read-domain clock; the block has one clock, and all state updates on its rising edge.
REQ-004 rrst  input  1  reset, asynchronous, active-high.
REQ-005 wptr  input  ADDRSIZE+1  Gray-coded write pointer from the write domain, asynchronous to rclk.
REQ-006 rdata  input  DATASIZE  memory read data, a combinational function of raddr.
REQ-007 raddr  output  ADDRSIZE  memory read address.
REQ-008 rptr  output  ADDRSIZE+1  registered Gray-coded read pointer, sent to the write domain.
REQ-009 rempty  output  1  registered FIFO-empty flag.
REQ-010 dout  output  DATASIZE  registered output data.
REQ-011 dout_valid  output  1  dout holds a valid word.
REQ-012 dout_ready  input  1  consumer accepts dout this cycle.
REQ-013 rcount  output  ADDRSIZE+1  words in memory not yet popped, as seen through the synchronized wptr (0..DEPTH).

Function
REQ-014 wptr shall pass through a 2-flop synchronizer (rq1_wptr -> rq2_wptr); no other logic shall use the unsynchronized wptr.
REQ-015 The block shall keep a binary read pointer rbin [ADDRSIZE:0]; raddr shall equal rbin[ADDRSIZE-1:0].
REQ-016 rptr shall be registered as rbin^(rbin>>1) and shall always be the Gray code of the current rbin.
REQ-017 The pop signal shall be pop = !rempty && (!dout_valid || dout_ready).
REQ-018 On a pop, rbin shall increment by 1, modulo 2^(ADDRSIZE+1).
REQ-019 On a pop, dout shall load rdata and dout_valid shall be set to 1.
REQ-020 rempty shall be registered as (Gray(rbin_next) == rq2_wptr), where rbin_next = rbin + pop.
REQ-021 The output stage shall be a 2-state FSM, IDLE (dout_valid=0) and VALID (dout_valid=1).
REQ-022 IDLE -> VALID on pop.
REQ-023 VALID -> VALID on pop; a new word loads in the same cycle as the handshake, giving one word per cycle of throughput.
REQ-024 VALID -> IDLE on dout_ready with no pop.
REQ-025 VALID with !dout_ready shall hold dout, rbin, raddr and rptr unchanged.
REQ-026 rcount shall equal Gray2Bin(rq2_wptr) - rbin, modulo 2^(ADDRSIZE+1).
REQ-027 rcount = DEPTH (MSBs differ, low bits equal) shall be a legal full condition.
REQ-028 Latency: a wptr change that settles before rclk edge N shall give rq2_wptr at edge N+1 and rempty=0 at edge N+2.
REQ-029 With the output stage IDLE, the same wptr change shall give dout_valid=1 with the word at edge N+3.
REQ-030 When rbin_next matches rq2_wptr, rempty shall rise in the same cycle as the final pop, so no pop occurs when the FIFO is empty.
REQ-031 Wrap-around: rbin wraps from 2^(ADDRSIZE+1)-1 to 0 and raddr wraps from DEPTH-1 to 0 with no gap or repeated word.
REQ-032 If wptr changes in the same cycle as the last pop, rempty shall rise, then fall again once the new wptr is synchronized.

Reset
REQ-033 rrst=1 shall immediately, without waiting for rclk, force rbin=0, rptr=0, rq1_wptr=rq2_wptr=0, rempty=1, dout_valid=0, dout=0 and FSM=IDLE; rcount shall then be 0.
REQ-034 Reset asserted mid-transfer shall discard the word in dout.
REQ-035 After rrst deasserts, operation shall resume from address 0 on the first rclk edge.

Verification (DATASIZE=8, ADDRSIZE=4)
REQ-036 Reset: assert rrst between clock edges while dout_valid=1 and rbin=7 -> dout_valid=0, rempty=1, rptr=5'b00000, rcount=0 before the next edge.
REQ-037 Single word: mem[0]=8'hA5, wptr 00000->00001 before edge 1, dout_ready=1 -> rempty=0 after edge 3; dout=8'hA5 and dout_valid=1 after edge 4; raddr=1, rptr=00001; rempty=1 after edge 4; dout_valid=0 after edge 5.
REQ-038 Backpressure: words 8'h11, 8'h22, 8'h33 written, dout_ready=0 -> dout holds 8'h11, raddr=1, rcount=2 indefinitely; with dout_ready=1, the bench sees 8'h22 and 8'h33 on consecutive cycles.
REQ-039 Streaming: 16 words 8'h00..8'h0F, dout_ready=1 -> one word per cycle in order; then rempty=1 and dout_valid=0 one cycle after the last word.
REQ-040 Wrap: 20 words pushed and popped -> rbin passes 15->16 with rptr=5'b11000 and raddr=0; all 20 words arrive in order.
REQ-041 Full: rbin=0 and wptr=5'b11000 (Gray of 16) synchronized, dout_ready=0, FSM=IDLE -> rcount=16 and rempty=0; the first pop reads raddr 0.
